// File: rtl/btn_ctrl_if.sv
// Button event stream: one press/release/repeat event per accepted transfer.
interface btn_ctrl_if #(
  parameter int N_BTN = 4
);
  localparam int BW = $clog2(N_BTN);

  logic          ev_valid;
  logic          ev_ready;
  logic [BW-1:0] ev_btn;
  logic [1:0]    ev_kind;

  modport master (output ev_valid, output ev_btn, output ev_kind, input ev_ready);
  modport slave  (input ev_valid, input ev_btn, input ev_kind, output ev_ready);
endinterface

// File: rtl/btn_ctrl.sv
// Shared-divider button front-end: debounce, edge/auto-repeat detection and
// round-robin merge of per-button events onto one valid/ready stream.
module btn_ctrl #(
  parameter int CLK_DIV      = 1250000,
  parameter int N_BTN        = 4,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] bin,
  input  logic             clr_ovr,
  output logic             tick,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] overrun,
  btn_ctrl_if.master       ev
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(N_BTN);
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HC_MAX    = HW'(REPEAT_DELAY);
  // A rate not shorter than the delay degenerates to restarting the full hold count.
  localparam logic [HW-1:0] HC_RELOAD =
    (REPEAT_RATE >= REPEAT_DELAY) ? '0 : HW'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [1:0] K_PRESS = 2'b00;
  localparam logic [1:0] K_REL   = 2'b01;
  localparam logic [1:0] K_REP   = 2'b10;

  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
    return (v == HC_MAX) ? v : v + 1'b1;
  endfunction

  logic [CW-1:0]    cnt;
  logic [N_BTN-1:0] sync_p0, sync_p1, smp;
  logic [N_BTN-1:0] lvl_nxt, ev_new, pv, grant, ovr_set;
  logic [1:0]       kind_new [N_BTN];
  logic [1:0]       pk       [N_BTN];
  logic [HW-1:0]    hc       [N_BTN];
  logic [HW-1:0]    hc_nxt   [N_BTN];
  logic [BW-1:0]    rr_ptr, win, rr_nxt;
  logic             any, load;
  logic             vld_p2;
  logic [BW-1:0]    btn_p2;
  logic [1:0]       kind_p2;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Stage p0/p1: two-flop synchronizer on the raw button levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bin;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    lvl_nxt = level;
    ev_new  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      kind_new[i] = K_PRESS;
      hc_nxt[i]   = hc[i];
      if (tick) begin
        if (sync_p1[i] == smp[i]) lvl_nxt[i] = sync_p1[i];
        if (lvl_nxt[i] != level[i]) begin
          ev_new[i]   = 1'b1;
          kind_new[i] = lvl_nxt[i] ? K_PRESS : K_REL;
          hc_nxt[i]   = '0;
        end else if (level[i]) begin
          hc_nxt[i] = sat_inc(hc[i]);
          if (hc_nxt[i] == HC_MAX) begin
            ev_new[i]   = 1'b1;
            kind_new[i] = K_REP;
            hc_nxt[i]   = HC_RELOAD;
          end
        end
      end
    end
  end

  always_comb begin
    any = 1'b0;
    win = rr_ptr;
    for (int k = 0; k < N_BTN; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N_BTN;
      if (!any && pv[idx]) begin
        any = 1'b1;
        win = BW'(idx);
      end
    end
  end

  assign load    = !vld_p2 || ev.ev_ready;
  assign grant   = (load && any) ? (N_BTN'(1) << win) : '0;
  assign ovr_set = ev_new & pv & ~grant;
  assign rr_nxt  = (win == BW'(N_BTN - 1)) ? '0 : win + 1'b1;

  // Stage p1 -> debounced level, hold counters and per-button pending slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp     <= '0;
      level   <= '0;
      pv      <= '0;
      overrun <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hc[i] <= '0;
        pk[i] <= '0;
      end
    end else begin
      if (tick) smp <= sync_p1;
      level <= lvl_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        hc[i] <= hc_nxt[i];
        if (ev_new[i]) begin
          pv[i] <= 1'b1;
          pk[i] <= kind_new[i];
        end else if (grant[i]) begin
          pv[i] <= 1'b0;
        end
      end
      overrun <= (clr_ovr ? '0 : overrun) | ovr_set;
    end
  end

  // Stage p2: output event register, refilled round-robin whenever free or accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      btn_p2  <= '0;
      kind_p2 <= '0;
      rr_ptr  <= '0;
    end else if (load) begin
      if (any) begin
        vld_p2  <= 1'b1;
        btn_p2  <= win;
        kind_p2 <= pk[win];
        rr_ptr  <= rr_nxt;
      end else begin
        vld_p2  <= 1'b0;
      end
    end
  end

  assign ev.ev_valid = vld_p2;
  assign ev.ev_btn   = btn_p2;
  assign ev.ev_kind  = kind_p2;
endmodule

// File: tb/tb_btn_ctrl.sv
// Directed bench for btn_ctrl with CLK_DIV=4, N_BTN=4, REPEAT_DELAY=3, REPEAT_RATE=2.
module tb_btn_ctrl;
  localparam int CLK_DIV = 4, N_BTN = 4, REPEAT_DELAY = 3, REPEAT_RATE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bin = '0;
  logic       clr_ovr = 1'b0;
  logic       tick;
  logic [3:0] level, overrun;

  btn_ctrl_if #(.N_BTN(N_BTN)) ev ();

  btn_ctrl #(.CLK_DIV(CLK_DIV), .N_BTN(N_BTN), .REPEAT_DELAY(REPEAT_DELAY),
             .REPEAT_RATE(REPEAT_RATE)) dut (
    .clk(clk), .rst(rst), .bin(bin), .clr_ovr(clr_ovr), .tick(tick),
    .level(level), .overrun(overrun), .ev(ev)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int btn; int kind; int cyc; } rec_t;
  rec_t q[$];

  // Accepted-event log; cyc is the index of the cycle since reset release
  always @(posedge clk) begin
    if (rst) cyc = 0;
    else begin
      if (ev.ev_valid === 1'b1 && ev.ev_ready === 1'b1)
        q.push_back('{int'(ev.ev_btn), int'(ev.ev_kind), cyc});
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step(1);
  endtask

  function automatic int first_tick(input int c);
    int t = c;
    while (t % CLK_DIV != CLK_DIV - 1) t++;
    return t;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; bin = '0; clr_ovr = 1'b0; ev.ev_ready = 1'b1;
    step(2);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    ev.ev_ready = 1'b1;
    step(3);
    @(negedge clk);
    checks++;
    if ({tick, level, ev.ev_valid, ev.ev_btn, ev.ev_kind, overrun} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {tick, level, ev.ev_valid, ev.ev_btn, ev.ev_kind, overrun});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (tick !== (c % 4 == 3)) begin
        errors++;
        $display("FAIL divider_tick cycle %0d: got %b expected %b", c, tick, (c % 4 == 3));
      end
      checks++;
      if ({level, ev.ev_valid, overrun} !== 9'd0) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d: got %h expected 0", c, {level, ev.ev_valid, overrun});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_debounce();
    int c, t2;
    bin[1] = 1'b1;
    step(4);
    bin[1] = 1'b0;
    step(20);
    checks++;
    if (level !== 4'b0000 || q.size() != 0) begin
      errors++;
      $display("FAIL glitch_filtered: level %b events %0d expected 0000 and 0", level, q.size());
    end
    c = cyc;
    bin[1] = 1'b1;
    t2 = first_tick(c + 2) + 4;
    goto(t2);
    @(negedge clk);
    checks++;
    if (level !== 4'b0000) begin
      errors++;
      $display("FAIL level_before_2nd_tick: got %b expected 0000", level);
    end
    goto(t2 + 1);
    @(negedge clk);
    checks++;
    if (level !== 4'b0010) begin
      errors++;
      $display("FAIL level_after_press: got %b expected 0010", level);
    end
    goto(t2 + 3);
    checks++;
    if (q.size() != 1) begin
      errors++;
      $display("FAIL press_count: got %0d expected 1", q.size());
    end else if (q[0].btn !== 1 || q[0].kind !== 0 || q[0].cyc !== t2 + 2) begin
      errors++;
      $display("FAIL press_event: got btn %0d kind %0d cyc %0d expected btn 1 kind 0 cyc %0d",
               q[0].btn, q[0].kind, q[0].cyc, t2 + 2);
    end
    bin[1] = 1'b0;
    step(24);
    checks++;
    if (q.size() != 2 || level !== 4'b0000) begin
      errors++;
      $display("FAIL release_btn1: events %0d level %b expected 2 and 0000", q.size(), level);
    end else if (q[1].btn !== 1 || q[1].kind !== 1) begin
      errors++;
      $display("FAIL release_btn1_kind: got btn %0d kind %0d expected btn 1 kind 1",
               q[1].btn, q[1].kind);
    end
    q.delete();
  endtask

  task automatic test_repeat();
    int c, t2;
    int exp_kind [5] = '{0, 2, 2, 2, 1};
    int exp_off  [5] = '{2, 14, 22, 30, 38};
    c = cyc;
    bin[2] = 1'b1;
    t2 = first_tick(c + 2) + 4;
    goto(t2 + 29);
    bin[2] = 1'b0;
    goto(t2 + 50);
    checks++;
    if (q.size() != 5) begin
      errors++;
      $display("FAIL repeat_count: got %0d expected 5", q.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (q.size() <= i) begin
        errors++;
        $display("FAIL repeat_ev%0d: missing, expected kind %0d", i, exp_kind[i]);
      end else if (q[i].btn !== 2 || q[i].kind !== exp_kind[i] || q[i].cyc !== t2 + exp_off[i]) begin
        errors++;
        $display("FAIL repeat_ev%0d: got btn %0d kind %0d cyc %0d expected btn 2 kind %0d cyc %0d",
                 i, q[i].btn, q[i].kind, q[i].cyc, exp_kind[i], t2 + exp_off[i]);
      end
    end
    q.delete();
  endtask

  task automatic test_arbitration();
    int c, t2;
    int exp_btn [3] = '{0, 1, 3};
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      c = cyc;
      bin = (pass == 0) ? 4'b1011 : 4'b0000;
      t2 = first_tick(c + 2) + 4;
      goto(t2 + 5);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q.size() <= i) begin
          errors++;
          $display("FAIL arb_pass%0d_ev%0d: missing, expected btn %0d", pass, i, exp_btn[i]);
        end else if (q[i].btn !== exp_btn[i] || q[i].kind !== pass || q[i].cyc !== t2 + 2 + i) begin
          errors++;
          $display("FAIL arb_pass%0d_ev%0d: got btn %0d kind %0d cyc %0d expected btn %0d kind %0d cyc %0d",
                   pass, i, q[i].btn, q[i].kind, q[i].cyc, exp_btn[i], pass, t2 + 2 + i);
        end
      end
      q.delete();
    end
  endtask

  task automatic test_back_pressure();
    int c, t2, bad;
    do_reset();
    ev.ev_ready = 1'b0;
    c = cyc;
    bin = 4'b0100;
    t2 = first_tick(c + 2) + 4;
    bad = 0;
    for (int k = 2; k <= 82; k++) begin
      goto(t2 + k);
      clr_ovr = (k == 25 || k == 28);
      @(negedge clk);
      if (ev.ev_valid !== 1'b1 || ev.ev_btn !== 2'd2 || ev.ev_kind !== 2'b00) bad++;
      if (k == 20 || k == 21 || k == 26 || k == 29) begin
        checks++;
        if (overrun !== ((k == 20 || k == 26) ? 4'b0000 : 4'b0100)) begin
          errors++;
          $display("FAIL overrun_k%0d: got %b expected %b", k, overrun,
                   (k == 20 || k == 26) ? 4'b0000 : 4'b0100);
        end
      end
      @(posedge clk); #1;
    end
    clr_ovr = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_stable: %0d unstable cycles expected 0", bad);
    end
    bin = 4'b0000;
    ev.ev_ready = 1'b1;
    step(30);
    checks++;
    if (q.size() != 4) begin
      errors++;
      $display("FAIL drain_count: got %0d expected 4", q.size());
    end else if (q[0].btn !== 2 || q[0].kind !== 0 || q[1].kind !== 2 || q[3].kind !== 1) begin
      errors++;
      $display("FAIL drain_order: got kinds %0d %0d %0d btn %0d expected 0 2 2 1 btn 2",
               q[0].kind, q[1].kind, q[3].kind, q[0].btn);
    end
    q.delete();
  endtask

  task automatic test_async_reset();
    int c, t2;
    do_reset();
    ev.ev_ready = 1'b0;
    c = cyc;
    bin = 4'b0011;
    t2 = first_tick(c + 2) + 4;
    goto(t2 + 13);
    @(negedge clk);
    checks++;
    if (ev.ev_valid !== 1'b1 || ev.ev_btn !== 2'd0 || overrun !== 4'b0010) begin
      errors++;
      $display("FAIL pre_reset_state: valid %b btn %0d overrun %b expected 1 0 0010",
               ev.ev_valid, ev.ev_btn, overrun);
    end
    #2;
    rst = 1'b1;
    bin = 4'b0000;
    #1;
    checks++;
    if ({ev.ev_valid, overrun, level} !== 9'd0) begin
      errors++;
      $display("FAIL async_clear: got %h expected 0", {ev.ev_valid, overrun, level});
    end
    @(negedge clk);
    checks++;
    if ({ev.ev_valid, overrun, level, tick} !== 10'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 0", {ev.ev_valid, overrun, level, tick});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ev.ev_ready = 1'b1;
    step(40);
    checks++;
    if (q.size() != 0 || ev.ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_event_after_reset: events %0d valid %b expected 0 0", q.size(), ev.ev_valid);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_repeat();
    test_arbitration();
    test_back_pressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_ctrl.md
# btn_ctrl

Multi-button front-end controller for the FFT1024 board. It owns one shared sample-tick divider and sequences debounce, edge detection and auto-repeat for all buttons. It arbitrates the resulting per-button events round-robin onto a single valid/ready event stream consumed by the FFT control logic. It replaces per-button divider instances, so all buttons share one counter.

## Interface
- CLK_DIV, 1250000: system clocks per sample tick (50 MHz / 1250000 = 40 Hz); must be >= 2.
- N_BTN, 4: number of buttons; must be >= 2.
- REPEAT_DELAY, 20: ticks of continuous hold before the first repeat event; must be >= 1.
- REPEAT_RATE, 4: ticks between subsequent repeat events; must be >= 1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- bin  in  N_BTN  raw button levels, active-high, asynchronous to clk.
- ev_ready  in  1  consumer accepts the event in the current cycle.
- clr_ovr  in  1  one-cycle pulse that clears all overrun flags.
- tick  out  1  one-clk pulse per sample period.
- level  out  N_BTN  debounced button levels.
- ev_valid  out  1  event present on ev_btn/ev_kind.
- ev_btn  out  clog2(N_BTN)  index of the button that produced the event.
- ev_kind  out  2  event type: 00 press, 01 release, 10 repeat; 11 is never driven.
- overrun  out  N_BTN  sticky flag: a pending event for that button was lost.

## Operation
- Divider: cnt counts 0..CLK_DIV-1 and then wraps to 0. tick = (cnt == CLK_DIV-1). After reset, the first tick is in cycle CLK_DIV-1.
- Synchronizer: bin passes through 2 flops every clk, giving s.
- Debounce: on each tick, smp <= s.
  - level[i] <= s[i] only if s[i] == smp[i], i.e. two consecutive tick samples agree.
  - Otherwise level[i] holds.
- Events are generated only in tick cycles:
  - Press: level[i] changes 0->1. The hold counter hc[i] is set to 0.
  - Release: level[i] changes 1->0. hc[i] is set to 0.
  - Repeat: while level[i] stays 1, hc[i] increments on each tick.
    - The first repeat fires on the tick where hc[i] reaches REPEAT_DELAY.
    - After that, hc[i] reloads to REPEAT_DELAY-REPEAT_RATE, so a repeat fires every REPEAT_RATE ticks.
    - hc[i] saturates and never wraps.
- Pending slot: each button has one slot {pv[i], pk[i]}.
  - A new event writes the slot.
  - If pv[i] is already 1 and the slot is not being granted in the same cycle:
    - the old event is replaced by the new one;
    - overrun[i] is set.
  - If the slot is granted in the same cycle, the new event loads with no overrun.
- clr_ovr clears all overrun bits. If a set and a clear land in the same cycle, set wins.
- Output register:
  - Loads when ev_valid == 0, or when ev_valid && ev_ready.
  - The loaded event is the round-robin winner among pv, searching from rr_ptr upward with wrap.
  - On load, the winner's pv is cleared and rr_ptr <= winner+1 mod N_BTN.
  - If no pv bit is set, ev_valid <= 0.
- Handshake: while ev_valid && !ev_ready, ev_btn and ev_kind hold stable. ev_valid never drops without acceptance.

## Timing
- Reset values:
  - cnt, sync flops, smp, level, hc, pv, pk: 0.
  - rr_ptr, ev_valid, ev_btn, ev_kind, overrun: 0.
  - tick is 0 during reset.
- Reset mid-operation clears everything immediately, including any un-accepted event.
- bin to s: 2 cycles.
- An edge on s needs 2 agreeing ticks before level changes.
- Tick in cycle T → level and pending visible in T+1 → ev_valid in T+2, provided the output register is free.
- Back-to-back throughput is one event per cycle while ev_ready = 1.
- Simultaneous events in the same tick are all captured. They are issued in round-robin order, one per cycle.
- Wrap-around: rr_ptr = N_BTN-1 wraps to 0. cnt wraps without a skipped or doubled tick.

## Test plan
Simulation settings: CLK_DIV=4, N_BTN=4, REPEAT_DELAY=3, REPEAT_RATE=2.
- Reset/divider: release rst → tick in cycles 3, 7, 11; all outputs 0 before the first event.
- Debounce: bin[1] high for 1 tick period only → no level change, no event. Then hold bin[1] high → level[1] = 1 and a single press event with ev_btn=1, ev_kind=00.
- Repeat: hold bin[2] → press, then repeat (10) 3 ticks later, then every 2 ticks. Release → release event (01); hc stops.
- Arbitration: press bin[0], bin[1], bin[3] in the same cycle with ev_ready=1 → events btn 0, 1, 3 on consecutive cycles. The next simultaneous set starts from btn 0, since rr_ptr wrapped.
- Back-pressure: ev_ready=0 with ev_valid=1 for 20 ticks → outputs stable. A second event for the same button → overrun set. clr_ovr → overrun cleared, unless a set occurs in the same cycle.
- Async reset asserted while ev_valid=1 and pv≠0 → ev_valid, pv and overrun are 0 on the next observed edge, with no event emitted afterwards.
